lfsr_burst_ctrl: RTL and testbench
==================================

Name: lfsr_burst_ctrl

Overview:
- Sequencer for the 4-bit LF_SR serial generator.
- Loads a seed into LF_SR, releases it, and collects its serial `out` bits (qualified by `vaild`) into WORD_W-bit words.
- Delivers a programmed number of words over a valid/ready handshake, then parks LF_SR in load and pulses done.
- Sits between software/test control and the LF_SR instance; owns LF_SR's `rest` and `seed` pins.

Parameters:
WORD_W, 8, bits per assembled output word (2..32)
LOAD_CYC, 2, cycles lfsr_rest is held low before release (>=1)

Ports:
clk  in  1  system clock, rising edge
rest  in  1  reset, synchronous, active-high
start  in  1  session request, sampled only in IDLE
seed_in  in  4  seed for the session
n_words  in  8  words to deliver per session
lfsr_rest  out  1  to LF_SR.rest; low = LF_SR held/loading seed, high = running
lfsr_seed  out  4  to LF_SR.seed
lfsr_out  in  1  from LF_SR.out
lfsr_vaild  in  1  from LF_SR.vaild; qualifies lfsr_out
word_out  out  WORD_W  assembled word
word_valid  out  1  word_out valid
word_ready  in  1  consumer accepts word
busy  out  1  session in progress
done  out  1  one-cycle pulse at session end
overrun  out  1  sticky: LF_SR bit arrived while a word was waiting

Behaviour:
- One clock (clk); reset is synchronous and active-high (rest); every register is updated only on the clk rising edge.
- Reset values:
  - state=IDLE.
  - lfsr_rest=0, lfsr_seed=0, word_out=0.
  - word_valid=0, busy=0, done=0, overrun=0.
  - All counters 0.
- rest dominates all other inputs. Asserting rest mid-session aborts at the next edge: word_valid drops with no handshake, and done is not pulsed.
- States: IDLE, LOAD, RUN, HOLD, DONE.
- Outputs decoded from the state register, with no extra latency:
  - lfsr_rest=1 only in RUN and HOLD.
  - busy=1 in LOAD, RUN and HOLD.
  - done=1 only in DONE.
- IDLE, start=1:
  - Capture lfsr_seed<=seed_in, except 4'b0000, which is replaced by 4'b0001 (lock-up avoidance).
  - Latch n_words into a word target.
  - Clear overrun, word count and bit count.
  - Next state is LOAD, or DONE if n_words==0.
- start is ignored outside IDLE, including in DONE.
- LOAD: stay exactly LOAD_CYC cycles, then go to RUN. lfsr_seed is stable for the whole session.
- RUN, on each cycle with lfsr_vaild=1:
  - shift <= {shift[WORD_W-2:0], lfsr_out} (first bit ends up in the MSB); bit count +1.
  - When the WORD_W-th bit is captured: word_out<=completed word, word_valid<=1, bit count<=0, go to HOLD.
  - lfsr_out is ignored when lfsr_vaild=0.
- HOLD:
  - word_out and word_valid are held stable until word_valid & word_ready.
  - LF_SR has no enable and keeps running. Any lfsr_vaild=1 cycle in HOLD (including the accept cycle) drops that bit and sets overrun.
- On accept: word count +1. If word count equals the target, go to DONE with word_valid<=0. Otherwise go to RUN with word_valid<=0, and collection restarts from bit 0.
- DONE: lasts one cycle (done=1, lfsr_rest=0), then goes to IDLE. Idle again in the following cycle; a new start is accepted from then on.
- Latency:
  - start accepted at edge T.
  - lfsr_rest rises at edge T+LOAD_CYC.
  - First word_valid appears the edge after the WORD_W-th qualified bit.
  - done is high the cycle after the final accept.
- word_valid never asserts outside HOLD. overrun holds until the next accepted start or rest.

Test Plan:
- Reset: rest=1 for 2 cycles with random inputs -> all outputs 0; start pulses under rest are ignored; state stays IDLE.
- Single word: seed_in=4'b1110, n_words=1, start 1 cycle.
  - lfsr_seed=4'hE; lfsr_rest low for 2 cycles, then high.
  - Bench drives vaild=1 with bits 1,0,1,1,0,0,1,0 -> word_out=8'hB2, word_valid=1.
  - word_ready=1 -> done pulses 1 cycle; lfsr_rest=0; busy=0.
- Zero seed / zero count:
  - seed_in=0, n_words=1 -> lfsr_seed=4'h1.
  - n_words=0 -> done 1 cycle after start; lfsr_rest never goes high; word_valid never asserts.
- Back-pressure: n_words=2, word_ready low for 3 cycles with vaild high in HOLD.
  - overrun=1; word_out stable.
  - After accept, the next 8 qualified bits form word 2; done after the 2nd accept.
- Gapped vaild: vaild toggling 1/0 -> only qualified bits are assembled; word_valid appears after the 8th qualified bit.
- Abort and ignore:
  - rest=1 during RUN after 5 bits -> reset values next edge, no done.
  - start asserted during busy -> no effect on lfsr_seed or counts.

Source files
------------

// File: rtl/lfsr_burst_ctrl_if.sv
// Word stream handshake between lfsr_burst_ctrl and its consumer.
// The master holds word_out/word_valid until word_ready accepts them.
interface lfsr_burst_ctrl_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output word_out,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_out,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/lfsr_burst_ctrl.sv
// Seeds and releases the LF_SR generator, packs its serial bits into
// words and delivers a programmed number of them over a handshake.
module lfsr_burst_ctrl #(
  parameter int WORD_W   = 8,
  parameter int LOAD_CYC = 2
) (
  input  logic                clk,
  input  logic                rest,
  input  logic                start,
  input  logic [3:0]          seed_in,
  input  logic [7:0]          n_words,
  output logic                lfsr_rest,
  output logic [3:0]          lfsr_seed,
  input  logic                lfsr_out,
  input  logic                lfsr_vaild,
  lfsr_burst_ctrl_if.master   wif,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  localparam int BW = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam int LW = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    HOLD,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [3:0]        seed_q;
  logic [7:0]        target;
  logic [7:0]        wcnt;
  logic [BW-1:0]     bcnt;
  logic [LW-1:0]     lcnt;
  logic [WORD_W-1:0] shift;
  logic [WORD_W-1:0] shift_nxt;
  logic [WORD_W-1:0] word_q;
  logic              valid_q;
  logic              ovr_q;
  logic [7:0]        wcnt_inc;
  logic              last_bit;
  logic              last_load;
  logic              accept;

  assign shift_nxt = {shift[WORD_W-2:0], lfsr_out};
  assign wcnt_inc  = wcnt + 8'd1;
  assign last_bit  = (bcnt == BW'(WORD_W - 1));
  assign last_load = (lcnt == LW'(LOAD_CYC - 1));
  assign accept    = (state == HOLD) && valid_q
                   && wif.word_ready;

  assign lfsr_rest = (state == RUN) || (state == HOLD);
  assign busy      = (state == LOAD) || lfsr_rest;
  assign done      = (state == DONE);
  assign lfsr_seed = seed_q;
  assign overrun   = ovr_q;
  assign wif.word_out   = word_q;
  assign wif.word_valid = valid_q;

  always_ff @(posedge clk) begin
    if (rest) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start)
        state_nxt = (n_words == 8'd0) ? DONE : LOAD;
      LOAD: if (last_load) state_nxt = RUN;
      RUN:  if (lfsr_vaild && last_bit)
        state_nxt = HOLD;
      HOLD: if (accept)
        state_nxt = (wcnt_inc == target) ? DONE : RUN;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      seed_q  <= '0;
      target  <= '0;
      wcnt    <= '0;
      bcnt    <= '0;
      lcnt    <= '0;
      shift   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          // an all-zero seed would lock the LFSR up
          seed_q <= (seed_in == 4'd0) ? 4'd1 : seed_in;
          target <= n_words;
          ovr_q  <= 1'b0;
          wcnt   <= '0;
          bcnt   <= '0;
          lcnt   <= '0;
        end
        LOAD: lcnt <= lcnt + LW'(1);
        RUN: if (lfsr_vaild) begin
          shift <= shift_nxt;
          if (last_bit) begin
            word_q  <= shift_nxt;
            valid_q <= 1'b1;
            bcnt    <= '0;
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        HOLD: begin
          // LF_SR cannot be stalled; bits seen here are lost
          if (lfsr_vaild) ovr_q <= 1'b1;
          if (accept) begin
            wcnt    <= wcnt_inc;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// Directed bench for lfsr_burst_ctrl: the bench plays LF_SR and the
// word consumer, checking outputs #1 after each rising edge.
module tb_lfsr_burst_ctrl;

  logic       clk = 1'b0;
  logic       rest;
  logic       start;
  logic [3:0] seed_in;
  logic [7:0] n_words;
  logic       lfsr_rest;
  logic [3:0] lfsr_seed;
  logic       lfsr_out;
  logic       lfsr_vaild;
  logic       busy;
  logic       done;
  logic       overrun;

  int n_cmp = 0;
  int n_err = 0;

  lfsr_burst_ctrl_if #(.WORD_W(8)) wif ();

  lfsr_burst_ctrl #(.WORD_W(8), .LOAD_CYC(2)) dut (
    .clk        (clk),
    .rest       (rest),
    .start      (start),
    .seed_in    (seed_in),
    .n_words    (n_words),
    .lfsr_rest  (lfsr_rest),
    .lfsr_seed  (lfsr_seed),
    .lfsr_out   (lfsr_out),
    .lfsr_vaild (lfsr_vaild),
    .wif        (wif.master),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      lfsr_vaild = 1'b1;
      lfsr_out   = w[i];
      tick();
    end
    lfsr_vaild = 1'b0;
    lfsr_out   = 1'b0;
  endtask

  task automatic begin_session(input logic [3:0] s,
                               input logic [7:0] n);
    seed_in = s;
    n_words = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    rest = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start      = 1'b1;
      seed_in    = 4'($urandom);
      n_words    = 8'($urandom_range(1, 255));
      lfsr_out   = 1'($urandom);
      lfsr_vaild = 1'($urandom);
      wif.word_ready = 1'($urandom);
      tick();
    end
    n_cmp++;
    if ({lfsr_rest, lfsr_seed, wif.word_out, wif.word_valid,
         busy, done, overrun} !== 17'd0) begin
      n_err++;
      $display("FAIL reset outs got %b want 0",
        {lfsr_rest, lfsr_seed, wif.word_out,
         wif.word_valid, busy, done, overrun});
    end
    rest = 1'b0; start = 1'b0; lfsr_vaild = 1'b0;
    lfsr_out = 1'b0; wif.word_ready = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle busy=%b done=%b want 0 0",
        busy, done);
    end
  endtask

  task automatic test_single_word();
    begin_session(4'hE, 8'd1);
    n_cmp++;
    if (lfsr_seed !== 4'hE || busy !== 1'b1 ||
        lfsr_rest !== 1'b0) begin
      n_err++;
      $display("FAIL single_load seed=%h busy=%b rest=%b want e 1 0",
        lfsr_seed, busy, lfsr_rest);
    end
    tick();
    n_cmp++;
    if (lfsr_rest !== 1'b0) begin
      n_err++;
      $display("FAIL single_load2 lfsr_rest=%b want 0", lfsr_rest);
    end
    tick();
    n_cmp++;
    if (lfsr_rest !== 1'b1) begin
      n_err++;
      $display("FAIL single_run lfsr_rest=%b want 1", lfsr_rest);
    end
    send_word(8'hB2);
    n_cmp++;
    if (wif.word_valid !== 1'b1 || wif.word_out !== 8'hB2) begin
      n_err++;
      $display("FAIL single_word valid=%b word=%h want 1 b2",
        wif.word_valid, wif.word_out);
    end
    wif.word_ready = 1'b1;
    tick();
    wif.word_ready = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || lfsr_rest !== 1'b0 || busy !== 1'b0 ||
        wif.word_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_done d=%b r=%b b=%b v=%b want 1 0 0 0",
        done, lfsr_rest, busy, wif.word_valid);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_idle done=%b busy=%b want 0 0",
        done, busy);
    end
  endtask

  task automatic test_zero_seed_count();
    logic seen;
    begin_session(4'h0, 8'd1);
    n_cmp++;
    if (lfsr_seed !== 4'h1) begin
      n_err++;
      $display("FAIL zero_seed seed=%h want 1", lfsr_seed);
    end
    rest = 1'b1;
    tick();
    rest = 1'b0;
    begin_session(4'h7, 8'd0);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || lfsr_rest !== 1'b0) begin
      n_err++;
      $display("FAIL zero_cnt d=%b b=%b r=%b want 1 0 0",
        done, busy, lfsr_rest);
    end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (lfsr_rest || wif.word_valid || done) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL zero_cnt_quiet activity=%b want 0", seen);
    end
  endtask

  task automatic test_back_pressure();
    logic ok;
    begin_session(4'h5, 8'd2);
    tick();
    tick();
    send_word(8'hA5);
    n_cmp++;
    if (wif.word_valid !== 1'b1 || wif.word_out !== 8'hA5) begin
      n_err++;
      $display("FAIL bp_word1 valid=%b word=%h want 1 a5",
        wif.word_valid, wif.word_out);
    end
    ok = 1'b1;
    lfsr_vaild = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lfsr_out = 1'(i);
      tick();
      if (wif.word_out !== 8'hA5 || wif.word_valid !== 1'b1)
        ok = 1'b0;
    end
    lfsr_vaild = 1'b0;
    n_cmp++;
    if (ok !== 1'b1 || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL bp_hold stable=%b overrun=%b want 1 1",
        ok, overrun);
    end
    wif.word_ready = 1'b1;
    tick();
    wif.word_ready = 1'b0;
    n_cmp++;
    if (wif.word_valid !== 1'b0 || busy !== 1'b1 ||
        done !== 1'b0) begin
      n_err++;
      $display("FAIL bp_accept1 v=%b b=%b d=%b want 0 1 0",
        wif.word_valid, busy, done);
    end
    send_word(8'h3C);
    n_cmp++;
    if (wif.word_valid !== 1'b1 || wif.word_out !== 8'h3C ||
        overrun !== 1'b1) begin
      n_err++;
      $display("FAIL bp_word2 v=%b word=%h ovr=%b want 1 3c 1",
        wif.word_valid, wif.word_out, overrun);
    end
    wif.word_ready = 1'b1;
    tick();
    wif.word_ready = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL bp_done done=%b want 1", done);
    end
    tick();
  endtask

  task automatic test_gapped_vaild();
    logic [7:0] w;
    w = 8'h69;
    begin_session(4'h9, 8'd1);
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL gap_ovr_clear overrun=%b want 0", overrun);
    end
    tick();
    tick();
    for (int i = 7; i >= 0; i--) begin
      lfsr_vaild = 1'b1;
      lfsr_out   = w[i];
      tick();
      if (i == 0) break;
      lfsr_vaild = 1'b0;
      lfsr_out   = ~w[i];
      tick();
    end
    lfsr_vaild = 1'b0;
    n_cmp++;
    if (wif.word_valid !== 1'b1 || wif.word_out !== 8'h69) begin
      n_err++;
      $display("FAIL gap_word valid=%b word=%h want 1 69",
        wif.word_valid, wif.word_out);
    end
    wif.word_ready = 1'b1;
    tick();
    wif.word_ready = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    begin_session(4'h3, 8'd3);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      lfsr_vaild = 1'b1;
      lfsr_out   = 1'b1;
      tick();
    end
    lfsr_vaild = 1'b0;
    rest = 1'b1;
    tick();
    rest = 1'b0;
    n_cmp++;
    if ({lfsr_rest, lfsr_seed, wif.word_valid, busy, done,
         overrun} !== 9'd0) begin
      n_err++;
      $display("FAIL abort outs got %b want 0",
        {lfsr_rest, lfsr_seed, wif.word_valid, busy, done,
         overrun});
    end
    tick();
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_nodone done=%b busy=%b want 0 0",
        done, busy);
    end
  endtask

  task automatic test_ignore_start();
    begin_session(4'h3, 8'd2);
    start   = 1'b1;
    seed_in = 4'h9;
    n_words = 8'd0;
    tick();
    tick();
    send_word(8'h81);
    n_cmp++;
    if (lfsr_seed !== 4'h3 || wif.word_out !== 8'h81) begin
      n_err++;
      $display("FAIL ign_seed seed=%h word=%h want 3 81",
        lfsr_seed, wif.word_out);
    end
    wif.word_ready = 1'b1;
    tick();
    wif.word_ready = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL ign_count busy=%b done=%b want 1 0",
        busy, done);
    end
    send_word(8'h7E);
    wif.word_ready = 1'b1;
    tick();
    wif.word_ready = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL ign_done done=%b want 1", done);
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL ign_in_done busy=%b done=%b want 0 0",
        busy, done);
    end
    tick();
  endtask

  initial begin
    rest = 1'b1; start = 1'b0; seed_in = '0; n_words = '0;
    lfsr_out = 1'b0; lfsr_vaild = 1'b0;
    wif.word_ready = 1'b0;
    test_reset();
    test_single_word();
    test_zero_seed_count();
    test_back_pressure();
    test_gapped_vaild();
    test_abort();
    test_ignore_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_err);
    $finish;
  end

endmodule
